// File: rtl/lane_concat_packer.sv
// Packs LANES consecutive IN_W-bit beats into one wide word with valid/ready on
// both sides; in_last flushes a partial word with unpopulated lanes left at zero.
module lane_concat_packer #(
    parameter int IN_W      = 8,
    parameter int LANES     = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [IN_W-1:0]            in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [LANES*IN_W-1:0]      out_data,
    output logic [$clog2(LANES+1)-1:0] out_count,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int W  = LANES * IN_W;
    localparam int CW = $clog2(LANES + 1);

    logic [CW-1:0] cnt;
    logic [W-1:0]  acc;
    logic [W-1:0]  placed;
    logic          accept;
    logic          complete;
    int            lane;

    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign complete = accept && ((cnt == CW'(LANES - 1)) || in_last);

    // Lane 0 is the first beat; it lands in the top slot when MSB_FIRST is set.
    always_comb begin
        lane   = 0;
        placed = '0;
        if (MSB_FIRST)
            lane = LANES - 1 - int'(cnt);
        else
            lane = int'(cnt);
        placed = W'(in_data) << (lane * IN_W);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (complete) begin
                out_data  <= acc | placed;
                out_count <= cnt + CW'(1);
                out_last  <= in_last;
                out_valid <= 1'b1;
                cnt       <= '0;
                acc       <= '0;
            end else if (accept) begin
                acc <= acc | placed;
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule
